// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_REM = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam int FLG_C = 0;
  localparam int FLG_L = 1;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_iter_unit.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
// The hi/lo "next" outputs show the value after the current iteration, so the
// owner can capture the final answer on the same edge that done is high.
module alu_iter_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  // mul: hi = partial product upper word, lo = multiplier shifting out / product low word
  // div: hi = partial remainder, lo = dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_q, lo_q, opd_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));

  // One iteration of each algorithm, evaluated from the current registers
  always_comb begin
    mul_add  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    mul_hi   = mul_add[WIDTH:1];
    mul_lo   = {mul_add[0], lo_q[WIDTH-1:1]};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opd_q};
    div_ge   = (div_sh >= {1'b0, opd_q});
    div_hi   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], div_ge};
    hi_nxt   = div_q ? div_hi : mul_hi;
    lo_nxt   = div_q ? div_lo : mul_lo;
  end

  // Load operands on start, then step until the down-counter reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= mode_div ? a_in : b_in;
      opd_q <= mode_div ? b_in : a_in;
      div_q <= mode_div;
      cnt_q <= CNT_W'(WIDTH);
    end else if (busy) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides, iterative MUL/DIV/REM and compare flags.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | ready for an op; single-cycle ops complete on accept
//   MUL     | shift-add multiply running in the iterative unit
//   DIV     | restoring divide running in the iterative unit
//   DONE    | result valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [3:0]       inst,
  input  logic             flag_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic [4:0]       flagreg
);

  import alu_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       inst_q;
  logic             fw_q;

  logic             idle;
  logic [WIDTH-1:0] fa, fb;
  logic [3:0]       fi;
  logic             ffw;
  logic [WIDTH:0]   sum;
  logic [4:0]       flags_c;
  logic             accept, div_op, start, cmpl;
  logic [WIDTH-1:0] res_lo_c, res_hi_c;
  logic             dz_c;

  logic             it_busy, it_done;
  logic [WIDTH-1:0] it_hi, it_lo;

  alu_iter_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode_div (div_op),
    .a_in     (reg1),
    .b_in     (reg2),
    .busy     (it_busy),
    .done     (it_done),
    .hi_nxt   (it_hi),
    .lo_nxt   (it_lo)
  );

  assign idle      = (state == ST_IDLE);
  assign in_ready  = idle;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && idle;
  assign div_op    = (inst[2:0] == OP_DIV) || (inst[2:0] == OP_REM);
  assign start     = accept && ((inst[2:0] == OP_MUL) || (div_op && (reg2 != '0)));
  assign cmpl      = (state_nxt == ST_DONE) && (state != ST_DONE);

  // Live inputs on the accept cycle, captured copies while iterating
  always_comb begin
    fa  = idle ? reg1 : a_q;
    fb  = idle ? reg2 : b_q;
    fi  = idle ? inst : inst_q;
    ffw = idle ? flag_write : fw_q;
  end

  // Compare-style flags from the add/subtract of the operands, independent of the op
  always_comb begin
    flags_c        = '0;
    sum            = {1'b0, fa} + {1'b0, (fi[3] ? ~fb : fb)} + {{WIDTH{1'b0}}, fi[3]};
    flags_c[FLG_C] = sum[WIDTH];
    flags_c[FLG_L] = (fb < fa);
    flags_c[FLG_F] = (fa[WIDTH-1] != fb[WIDTH-1]) && (sum[WIDTH-1] != fb[WIDTH-1]);
    flags_c[FLG_Z] = (sum[WIDTH-1:0] == '0);
    flags_c[FLG_N] = sum[WIDTH-1];
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (inst[2:0] == OP_MUL)  state_nxt = ST_MUL;
          else if (div_op)          state_nxt = (reg2 == '0) ? ST_DONE : ST_DIV;
          else                      state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (it_done)       state_nxt = ST_DONE;
        else if (!it_busy) state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Value to be registered on the completion edge
  always_comb begin
    res_lo_c = '0;
    res_hi_c = '0;
    dz_c     = 1'b0;
    unique case (state)
      ST_MUL: begin
        res_lo_c = it_lo;
        res_hi_c = it_hi;
      end
      ST_DIV: begin
        res_lo_c = (fi[2:0] == OP_DIV) ? it_lo : it_hi;
      end
      default: begin
        unique case (fi[2:0])
          OP_ADD:  res_lo_c = sum[WIDTH-1:0];
          OP_AND:  res_lo_c = fa & fb;
          OP_OR:   res_lo_c = fa | fb;
          OP_XOR:  res_lo_c = fa ^ fb;
          OP_DIV: begin
            res_lo_c = '1;
            dz_c     = 1'b1;
          end
          OP_REM: begin
            res_lo_c = fa;
            dz_c     = 1'b1;
          end
          OP_SH:   res_lo_c = fi[3] ? (fa >> fb[SH_W-1:0]) : (fa << fb[SH_W-1:0]);
          default: res_lo_c = '0;
        endcase
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture operands on accept so later input changes cannot disturb the op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      inst_q <= '0;
      fw_q   <= 1'b0;
    end else if (accept) begin
      a_q    <= reg1;
      b_q    <= reg2;
      inst_q <= inst;
      fw_q   <= flag_write;
    end
  end

  // Results and flags change only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
      flagreg   <= '0;
    end else if (cmpl) begin
      result    <= res_lo_c;
      result_hi <= res_hi_c;
      div_zero  <= dz_c;
      if (ffw) flagreg <= flags_c;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH = 16) with an expected-result scoreboard.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] reg1 = '0;
  logic [15:0] reg2 = '0;
  logic [3:0]  inst = '0;
  logic        flag_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        div_zero;
  logic [4:0]  flagreg;

  alu_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reg1       (reg1),
    .reg2       (reg2),
    .inst       (inst),
    .flag_write (flag_write),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .div_zero   (div_zero),
    .flagreg    (flagreg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [4:0]  mfl = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Flags {N,Z,F,L,C}; carry and zero come from plain integer arithmetic
  function automatic logic [4:0] model_flags(input logic [15:0] a, input logic [15:0] b, input logic sub);
    int          r;
    logic [15:0] s;
    logic        c, l, f, z, n;
    r = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    s = 16'(r);
    c = sub ? (a >= b) : (r > 65535);
    l = (b < a);
    f = (a[15] != b[15]) && (s[15] != b[15]);
    z = (s == 16'h0000);
    n = s[15];
    return {n, z, f, l, c};
  endfunction

  function automatic exp_t model_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [31:0] p;
    logic [3:0]  sh;
    e.lo = '0; e.hi = '0; e.dz = 1'b0; e.fl = '0; e.lat = 1;
    sh = b[3:0];
    case (op[2:0])
      3'd0: e.lo = op[3] ? 16'(a - b) : 16'(a + b);
      3'd1: e.lo = a & b;
      3'd2: e.lo = a | b;
      3'd3: e.lo = a ^ b;
      3'd4: begin
        p = 32'(a) * 32'(b);
        e.lo = p[15:0]; e.hi = p[31:16]; e.lat = 17;
      end
      3'd5: begin
        if (b == 0) begin e.lo = 16'hFFFF; e.dz = 1'b1; end
        else begin e.lo = a / b; e.lat = 17; end
      end
      3'd6: begin
        if (b == 0) begin e.lo = a; e.dz = 1'b1; end
        else begin e.lo = a % b; e.lat = 17; end
      end
      default: e.lo = op[3] ? (a >> sh) : (a << sh);
    endcase
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic fw);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("issue_in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1; inst = op; reg1 = a; reg2 = b; flag_write = fw;
    e = model_res(op, a, b);
    if (fw) mfl = model_flags(a, b, op[3]);
    e.fl = mfl;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reg1 = 16'($urandom); reg2 = 16'($urandom);
    inst = 4'($urandom); flag_write = 1'($urandom);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   lat;
    bit   rdy_seen;
    lat = 1; rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check("out_valid", 32'(out_valid), 32'(1));
    check("latency", 32'(lat), 32'(e.lat));
    check("in_ready_busy", 32'(rdy_seen), 32'(0));
    check("result", 32'(result), 32'(e.lo));
    check("result_hi", 32'(result_hi), 32'(e.hi));
    check("div_zero", 32'(div_zero), 32'(e.dz));
    check("flagreg", 32'(flagreg), 32'(e.fl));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; reg1 = 16'($urandom); reg2 = 16'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'(1));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_result", {result_hi, result}, {e.hi, e.lo});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'(1));
    check("release_out_valid", 32'(out_valid), 32'(0));
    check("release_result", 32'(result), 32'(e.lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] saved;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", {result_hi, result}, 32'h0);
    check("rst_flags", 32'(flagreg), 32'(0));
    check("rst_div_zero", 32'(div_zero), 32'(0));

    issue(4'b0000, 16'hFFFF, 16'h0001, 1'b1); collect(0);
    check("add_flags_const", 32'(flagreg), 32'(5'b01011));
    issue(4'b1000, 16'h0003, 16'h0005, 1'b1); collect(0);
    check("sub_flags_const", 32'(flagreg), 32'(5'b10000));
    issue(4'b1000, 16'h0007, 16'h0007, 1'b0); collect(0);
    issue(4'b0001, 16'hF0F0, 16'h3C3C, 1'b1); collect(0);
    issue(4'b0010, 16'hA000, 16'h0505, 1'b1); collect(0);
    issue(4'b0011, 16'hFFFF, 16'h8001, 1'b1); collect(0);
    issue(4'b0111, 16'h00F1, 16'h0013, 1'b1); collect(0);
    issue(4'b1111, 16'h8F00, 16'hFFF4, 1'b0); collect(0);

    issue(4'b0100, 16'h1234, 16'h0100, 1'b1); collect(0);
    issue(4'b1100, 16'hFFFF, 16'hFFFF, 1'b1); collect(0);
    issue(4'b0101, 16'd100, 16'd7, 1'b1); collect(0);
    issue(4'b0110, 16'd100, 16'd7, 1'b1); collect(0);
    issue(4'b0101, 16'hFFFF, 16'h0001, 1'b0); collect(0);
    issue(4'b0101, 16'h0042, 16'h0000, 1'b1); collect(0);
    issue(4'b0110, 16'h0042, 16'h0000, 1'b1); collect(0);
    issue(4'b0110, 16'hBEEF, 16'h8000, 1'b1); collect(0);

    issue(4'b0011, 16'h1357, 16'h2468, 1'b1); collect(5);
    issue(4'b0000, 16'h0010, 16'h0020, 1'b1); collect(0);

    saved = mfl;
    issue(4'b0100, 16'h00FF, 16'h00FF, 1'b1);
    mfl = saved;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_result", {result_hi, result}, 32'h0);
    check("abort_div_zero", 32'(div_zero), 32'(0));
    check("abort_flags", 32'(flagreg), 32'(0));
    void'(sb.pop_back());
    mfl = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_idle_out_valid", 32'(out_valid), 32'(0));
    issue(4'b0000, 16'd2, 16'd3, 1'b1); collect(0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised next-generation CPU ALU with a valid/ready handshake on both the operand side and the result side.
- Keeps the single-cycle ADD/SUB/AND/OR/XOR ops and adds logical shifts.
- Adds a multi-cycle unsigned multiplier (full 2*WIDTH product) and a restoring unsigned divider/remainder unit.
- Flags register (C/L/F/Z/N) is updated on op completion; the block sits between the register-file read stage and writeback.

Parameters:
- WIDTH, 16, datapath width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  block can accept an op
- reg1  in  WIDTH  operand A
- reg2  in  WIDTH  operand B
- inst  in  4  op code; [2:0] selects the op, [3] is the modifier
- flag_write  in  1  update flags when this op completes
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  low result word
- result_hi  out  WIDTH  MUL high word; 0 for all other ops
- div_zero  out  1  DIV/REM issued with reg2 == 0
- flagreg  out  5  {N,Z,F,L,C} = bits [4:0] as {4,3,2,1,0}

Behaviour:
- Op codes, selected by inst[2:0]:
  - 000: ADD, or SUB when inst[3] = 1 (sum = A + (inst[3] ? ~B : B) + inst[3]).
  - 001: AND.
  - 010: OR.
  - 011: XOR.
  - 100: MUL, unsigned; inst[3] is ignored.
  - 101: DIV quotient, unsigned.
  - 110: REM, unsigned.
  - 111: shift by B[$clog2(WIDTH)-1:0]; left logical when inst[3] = 0, right logical when inst[3] = 1.
- Accept: the edge where in_valid && in_ready. reg1, reg2, inst and flag_write are captured; later changes on the inputs have no effect.
- States:
  - IDLE -> DONE: single-cycle op, or DIV/REM with B == 0.
  - IDLE -> MUL: on accept of MUL.
  - IDLE -> DIV: on accept of DIV/REM with B != 0.
  - MUL -> DONE and DIV -> DONE: after WIDTH iterations.
  - DONE -> IDLE: on out_ready.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Latency from the accept edge to out_valid high:
  - single-cycle ops: 1 cycle;
  - MUL and DIV/REM: WIDTH+1 cycles.
- Maximum throughput is one op per 2 cycles.
- MUL: shift-add, one product bit per cycle. {result_hi, result} = A*B exactly.
- DIV/REM: restoring divide, one quotient bit per cycle. result = quotient or remainder; result_hi = 0.
- Divide by zero: no iteration. result = all ones for DIV, A for REM; div_zero = 1.
- Flags always follow compare semantics of the captured operands, whatever the op:
  - C = carry out of sum.
  - L = (B < A), unsigned.
  - F = (A[msb] != B[msb]) && (sum[msb] != B[msb]).
  - Z = (sum[WIDTH-1:0] == 0).
  - N = sum[msb].
  - sum uses the captured inst[3].
- flagreg is written at the edge entering DONE, only if the captured flag_write = 1; otherwise it holds.
- Holding DONE: result, result_hi and div_zero stay stable while out_valid && !out_ready, for any number of cycles. in_valid is ignored (in_ready = 0).
- result, result_hi and div_zero keep their value after DONE -> IDLE until the next completion.
- Reset: state = IDLE; result, result_hi, flagreg and div_zero = 0; out_valid = 0; in_ready = 1 one cycle after release. Reset during MUL/DIV/DONE aborts the op with no flag update and no result.

Decomposition:
- Shared package alu_pkg holds:
  - op code localparams: OP_ADD, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_REM, OP_SH;
  - flag bit indices: FLG_C = 0, FLG_L = 1, FLG_F = 2, FLG_Z = 3, FLG_N = 4;
  - state encoding.
- One sub-module, alu_iter_unit: the shared iterative shift-add/restoring-subtract datapath with start/busy/done and its own counter.
- The top level keeps the FSM, single-cycle ops, flags and handshake.

Test Plan (WIDTH = 16):
- ADD A=0xFFFF, B=0x0001, flag_write=1 -> result 0x0000, C=1, Z=1, N=0; out_valid 1 cycle after accept.
- SUB inst=4'b1000, A=0x0003, B=0x0005 -> result 0xFFFE, N=1, C=0, L=0, Z=0. Repeat with flag_write=0 -> flagreg unchanged.
- MUL A=0x1234, B=0x0100 -> result_hi 0x0012, result 0x3400; out_valid exactly 17 cycles after accept; in_ready low throughout.
- DIV A=100, B=7 -> result 14; REM -> 2; DIV A=0x0042, B=0 -> result 0xFFFF, div_zero=1, latency 1; REM with B=0 -> result 0x0042.
- Backpressure: hold out_ready=0 for 5 cycles after completion while driving in_valid=1 -> result stable, no new accept; out_ready=1 -> IDLE, next op accepted.
- Assert rst_n=0 mid-MUL (cycle 8) -> all outputs 0 immediately, flagreg 0. After release, ADD 2+3 -> result 5.
